// File: rtl/cp0_intc_pkg.sv
// cp0_intc_pkg: register map, reset constants and shared helpers for cp0_intc
package cp0_intc_pkg;
    localparam int INTC_NUM_IRQ_DEF = 8;
    localparam logic [4:0] INTC_PEND = 5'd0;
    localparam logic [4:0] INTC_MASK = 5'd1;
    localparam logic [4:0] INTC_MODE = 5'd2;
    localparam logic [4:0] INTC_FORCE = 5'd3;
    localparam logic [4:0] INTC_COUNT = 5'd9;
    localparam logic [4:0] INTC_COMPARE = 5'd11;
    localparam logic [31:0] INTC_COMPARE_RST = 32'hFFFF_FFFF;

    // index of the lowest set bit, 0 when the vector is empty
    function automatic logic [4:0] lowest_bit(input logic [31:0] v);
        lowest_bit = 5'd0;
        for (int i = 31; i >= 0; i--)
            if (v[i]) lowest_bit = 5'(i);
    endfunction
endpackage

// File: rtl/intc_sync.sv
// intc_sync: SYNC_STAGES-deep, NUM_IRQ-wide synchroniser with asynchronous clear
module intc_sync #(
    parameter int NUM_IRQ = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic [NUM_IRQ-1:0] d,
    output logic [NUM_IRQ-1:0] q
);
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] stg;

    // shift raw lines through the flop chain; the oldest stage is the output
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n)
        if (!cpu_rst_n) stg <= '0;
        else stg <= {stg[SYNC_STAGES-2:0], d};

    assign q = stg[SYNC_STAGES-1];
endmodule

// File: rtl/cp0_intc.sv
// cp0_intc: CP0 interrupt controller with edge/level channels and optional Count/Compare timer (INTC_TIMER_EN)
module cp0_intc
    import cp0_intc_pkg::*;
#(
    parameter int NUM_IRQ = INTC_NUM_IRQ_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               we,
    input  logic [4:0]         waddr,
    input  logic [31:0]        wdata,
    input  logic               re,
    input  logic [4:0]         raddr,
    output logic [31:0]        rdata,
    output logic [NUM_IRQ-1:0] irq_pend_o,
    output logic               int_req_o,
    output logic [ID_W-1:0]    irq_id_o,
    output logic               timer_int_o
);
    logic [NUM_IRQ-1:0] sync, src, src_d, pend, pend_d, mask, mode, wbits, w1c, frc, chg;
    logic [31:0] count, compare;
    logic unused;

    assign unused = ^wdata;
    assign wbits = wdata[NUM_IRQ-1:0];

    intc_sync #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .cpu_clk_50M(cpu_clk_50M),
        .cpu_rst_n(cpu_rst_n),
        .d(irq_i),
        .q(sync)
    );

    assign src = sync | (NUM_IRQ'(timer_int_o) << (NUM_IRQ - 1));

    // next pending: level follows source, edge latches rises over W1C, FORCE sets, mode change clears
    always_comb begin
        w1c = (we && waddr == INTC_PEND) ? wbits : '0;
        frc = (we && waddr == INTC_FORCE) ? wbits : '0;
        chg = (we && waddr == INTC_MODE) ? (wbits ^ mode) : '0;
        pend_d = ((mode & ((pend & ~w1c) | (src & ~src_d))) | (~mode & src) | frc) & ~chg;
    end

    // pending, edge history, mask/mode registers and the registered masked vector
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n)
        if (!cpu_rst_n) begin
            pend <= '0;
            src_d <= '0;
            mask <= '0;
            mode <= '0;
            irq_pend_o <= '0;
        end else begin
            pend <= pend_d;
            src_d <= src;
            irq_pend_o <= pend & mask;
            if (we && waddr == INTC_MASK) mask <= wbits;
            if (we && waddr == INTC_MODE) mode <= wbits;
        end

    assign int_req_o = |irq_pend_o;
    assign irq_id_o = ID_W'(lowest_bit(32'(irq_pend_o)));

`ifdef INTC_TIMER_EN
    logic tgl, timer_q;

    // half-rate counter with sticky match flag; software writes override the hardware update
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n)
        if (!cpu_rst_n) begin
            count <= '0;
            compare <= INTC_COMPARE_RST;
            tgl <= 1'b0;
            timer_q <= 1'b0;
        end else begin
            tgl <= (we && waddr == INTC_COUNT) ? 1'b0 : ~tgl;
            if (we && waddr == INTC_COUNT) count <= wdata;
            else if (tgl) count <= count + 32'd1;
            if (we && waddr == INTC_COMPARE) begin
                compare <= wdata;
                timer_q <= 1'b0;
            end else if (tgl && !(we && waddr == INTC_COUNT) && count == compare) timer_q <= 1'b1;
        end

    assign timer_int_o = timer_q;
`else
    assign count = '0;
    assign compare = '0;
    assign timer_int_o = 1'b0;
`endif

    // combinational register read port
    always_comb
        rdata = !re ? '0 :
                raddr == INTC_PEND ? 32'(pend) :
                raddr == INTC_MASK ? 32'(mask) :
                raddr == INTC_MODE ? 32'(mode) :
                raddr == INTC_COUNT ? count :
                raddr == INTC_COMPARE ? compare : '0;
endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: directed and randomized self-checking bench for cp0_intc
module tb_cp0_intc;
    import cp0_intc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq_i;
    logic        we, re;
    logic [4:0]  waddr, raddr;
    logic [31:0] wdata, rdata;
    logic [7:0]  irq_pend_o;
    logic        int_req_o;
    logic [2:0]  irq_id_o;
    logic        timer_int_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] irq_before [0:4095];
    logic [7:0] mask_after [0:4095];
    logic [7:0] mdl_mask = 8'h00;

    cp0_intc dut (
        .cpu_clk_50M(clk),
        .cpu_rst_n(rst_n),
        .irq_i(irq_i),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .re(re),
        .raddr(raddr),
        .rdata(rdata),
        .irq_pend_o(irq_pend_o),
        .int_req_o(int_req_o),
        .irq_id_o(irq_id_o),
        .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        irq_before[cyc+1] = irq_i;
        @(posedge clk);
        #1;
        cyc++;
        mask_after[cyc] = mdl_mask;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1;
        waddr = a;
        wdata = d;
        if (a == INTC_MASK) mdl_mask = d[7:0];
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        re = 1'b1;
        raddr = a;
        #1;
        chk(tag, rdata, exp);
        re = 1'b0;
    endtask

    function automatic logic [2:0] lowest(input logic [7:0] v);
        logic [2:0] r = 3'd0;
        logic found = 1'b0;
        for (int i = 0; i < 8; i++)
            if (v[i] && !found) begin
                r = 3'(i);
                found = 1'b1;
            end
        return r;
    endfunction

`ifdef INTC_TIMER_EN
    localparam logic [31:0] CMP_RST_EXP = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] CMP_RST_EXP = 32'h0;
`endif

    initial begin
        logic [7:0] exp_p;
        int rstart;
        rst_n = 1'b0;
        irq_i = '0;
        we = 1'b0;
        re = 1'b0;
        waddr = '0;
        raddr = '0;
        wdata = '0;
        repeat (3) tick();
        chk("rst_pend_o", 32'(irq_pend_o), 32'h0);
        chk("rst_int_req", 32'(int_req_o), 32'h0);
        rst_n = 1'b1;
        tick();
        rd("rst_compare", INTC_COMPARE, CMP_RST_EXP);
        rd("rst_mask", INTC_MASK, 32'h0);
        re = 1'b0;
        raddr = INTC_COMPARE;
        #1;
        chk("rdata_re0", rdata, 32'h0);

        wr(INTC_MODE, 32'h01);
        wr(INTC_MASK, 32'h01);
        irq_i = 8'h01;
        tick();
        irq_i = 8'h00;
        tick();
        tick();
        chk("edge_before_lat", 32'(int_req_o), 32'h0);
        tick();
        chk("edge_req", 32'(int_req_o), 32'h1);
        chk("edge_id", 32'(irq_id_o), 32'h0);
        repeat (3) tick();
        chk("edge_hold", 32'(int_req_o), 32'h1);
        rd("edge_pend_rd", INTC_PEND, 32'h01);
        wr(INTC_PEND, 32'h01);
        chk("w1c_same", 32'(int_req_o), 32'h1);
        tick();
        chk("w1c_drop", 32'(int_req_o), 32'h0);

        wr(INTC_MODE, 32'h00);
        wr(INTC_MASK, 32'h0C);
        irq_i = 8'h08;
        repeat (3) tick();
        chk("lvl_before_lat", 32'(int_req_o), 32'h0);
        tick();
        chk("lvl_id3", 32'(irq_id_o), 32'h3);
        irq_i = 8'h0C;
        repeat (4) tick();
        chk("lvl_id2", 32'(irq_id_o), 32'h2);
        wr(INTC_PEND, 32'h0C);
        tick();
        chk("lvl_w1c_noeffect", 32'(irq_pend_o), 32'h0C);
        irq_i = 8'h00;
        repeat (3) tick();
        chk("lvl_drop_wait", 32'(int_req_o), 32'h1);
        tick();
        chk("lvl_drop", 32'(int_req_o), 32'h0);

        wr(INTC_MODE, 32'h02);
        wr(INTC_MASK, 32'h02);
        irq_i = 8'h02;
        tick();
        irq_i = 8'h00;
        repeat (4) tick();
        chk("col_first", 32'(irq_pend_o), 32'h02);
        irq_i = 8'h02;
        tick();
        irq_i = 8'h00;
        tick();
        wr(INTC_PEND, 32'h02);
        rd("col_set_wins", INTC_PEND, 32'h02);
        tick();
        chk("col_pend_o", 32'(irq_pend_o), 32'h02);
        wr(INTC_PEND, 32'h02);
        rd("col_cleared", INTC_PEND, 32'h00);

        wr(INTC_MODE, 32'h00);
        wr(INTC_MASK, 32'h80);
        wr(INTC_COMPARE, 32'd5);
        wr(INTC_COUNT, 32'd0);
`ifdef INTC_TIMER_EN
        repeat (11) tick();
        chk("tmr_early", 32'(timer_int_o), 32'h0);
        tick();
        chk("tmr_hit", 32'(timer_int_o), 32'h1);
        tick();
        chk("tmr_req_lat", 32'(int_req_o), 32'h0);
        tick();
        chk("tmr_req", 32'(int_req_o), 32'h1);
        chk("tmr_id", 32'(irq_id_o), 32'h7);
        wr(INTC_COMPARE, 32'h20);
        chk("tmr_clear", 32'(timer_int_o), 32'h0);
        rd("tmr_cmp_rd", INTC_COMPARE, 32'h20);
        wr(INTC_COUNT, 32'hFFFF_FFFF);
        rd("tmr_cnt_load", INTC_COUNT, 32'hFFFF_FFFF);
        tick();
        tick();
        rd("tmr_wrap", INTC_COUNT, 32'h0);
        wr(INTC_COMPARE, 32'h8000_0000);
`else
        repeat (14) tick();
        chk("notmr_int", 32'(timer_int_o), 32'h0);
        chk("notmr_req", 32'(int_req_o), 32'h0);
        rd("notmr_count", INTC_COUNT, 32'h0);
        rd("notmr_compare", INTC_COMPARE, 32'h0);
`endif
        repeat (4) tick();

        rstart = cyc;
        for (int k = 0; k < 150; k++) begin
            irq_i = 8'($urandom);
            if ($urandom_range(0, 7) == 0) wr(INTC_MASK, $urandom);
            else tick();
            if (cyc - rstart >= 4) begin
                exp_p = irq_before[cyc-3] & mask_after[cyc-1];
                chk("rnd_pend_o", 32'(irq_pend_o), 32'(exp_p));
                chk("rnd_req", 32'(int_req_o), 32'(|exp_p));
                chk("rnd_id", 32'(irq_id_o), 32'(lowest(exp_p)));
            end
        end

        irq_i = 8'h01;
        wr(INTC_MASK, 32'h01);
        repeat (4) tick();
        chk("pre_rst_req", 32'(int_req_o), 32'h1);
        rst_n = 1'b0;
        mdl_mask = 8'h00;
        #1;
        chk("async_pend_o", 32'(irq_pend_o), 32'h0);
        chk("async_req", 32'(int_req_o), 32'h0);
        chk("async_id", 32'(irq_id_o), 32'h0);
        chk("async_tmr", 32'(timer_int_o), 32'h0);
        irq_i = 8'h00;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        rd("rst2_compare", INTC_COMPARE, CMP_RST_EXP);
        rd("rst2_mask", INTC_MASK, 32'h0);
        wr(INTC_MASK, 32'h80);
        wr(INTC_FORCE, 32'h80);
        rd("force_rd0", INTC_FORCE, 32'h0);
        tick();
        chk("force_req", 32'(int_req_o), 32'h1);
        chk("force_id", 32'(irq_id_o), 32'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
